// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the CPU datapath.
// Two prioritised write ports (port 1 wins on an address collision), NUM_RD
// combinational read ports with optional same-cycle write forwarding, an
// optional hardwired zero entry, and a clear engine that zeroes one entry
// per cycle after reset or on request.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  input  logic                       w_ena0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       w_ena1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       init_busy,
  output logic                       wr_err,
  output logic                       collide
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic drop0;
  logic drop1;
  logic commit0;
  logic commit1;
  logic wr_err_nxt;
  logic collide_nxt;

  // init_busy is a direct decode of the state register, so it is glitch-free
  assign init_busy = (state == ST_CLEAR);

  // Qualify the write ports: protected-entry drops, port-1 priority, error/collision detection
  always_comb begin
    drop0       = (ZERO_REG != 0) && (waddr0 == ADDR_ZERO);
    drop1       = (ZERO_REG != 0) && (waddr1 == ADDR_ZERO);
    commit1     = w_ena1 && !drop1 && (state == ST_READY);
    commit0     = w_ena0 && !drop0 && (state == ST_READY) &&
                  !(commit1 && (waddr1 == waddr0));
    collide_nxt = w_ena0 && commit1 && (waddr0 == waddr1);
    wr_err_nxt  = (state == ST_CLEAR) && ((w_ena0 && !drop0) || (w_ena1 && !drop1));
  end

  // Next-state logic for the clear sequencer
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_ONE;
        if (clr_ptr == ADDR_LAST) begin
          state_nxt = ST_READY;
        end else begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = ADDR_ZERO;
        end else begin
          state_nxt   = ST_READY;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = ADDR_ZERO;
      end
    endcase
  end

  // State register, clear pointer and the registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= ADDR_ZERO;
      wr_err  <= 1'b0;
      collide <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      wr_err  <= wr_err_nxt;
      collide <= collide_nxt;
    end
  end

  // Storage array: not reset directly; the clear engine zeroes it entry by entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= DATA_ZERO;
      end else begin
        if (commit0) begin
          mem[waddr0] <= wdata0;
        end
        if (commit1) begin
          mem[waddr1] <= wdata1;
        end
      end
    end
  end

  // Combinational read ports with zero-entry masking and optional forwarding
  always_comb begin : read_ports
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    rdata = {(NUM_RD*DATA_W){1'b0}};
    ra    = ADDR_ZERO;
    rd    = DATA_ZERO;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      if (state == ST_CLEAR) begin
        rd = DATA_ZERO;
      end else if ((ZERO_REG != 0) && (ra == ADDR_ZERO)) begin
        rd = DATA_ZERO;
      end else if ((BYPASS != 0) && commit1 && (waddr1 == ra)) begin
        rd = wdata1;
      end else if ((BYPASS != 0) && commit0 && (waddr0 == ra)) begin
        rd = wdata0;
      end else begin
        rd = mem[ra];
      end
      rdata[k*DATA_W +: DATA_W] = rd;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios followed by randomized traffic, checked
// every cycle against a behavioural model of the register file. Two DUT
// copies share the stimulus: one with forwarding, one without.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        w_ena0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        w_ena1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata_byp;
  logic [63:0] rdata_nb;
  logic        busy_byp, busy_nb;
  logic        err_byp, err_nb;
  logic        col_byp, col_nb;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] model_mem [32];
  bit          model_clearing;
  int          model_pos;
  bit          model_err;
  bit          model_col;
  bit          armed = 1'b0;

  regfile_mp #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .w_ena0(w_ena0), .waddr0(waddr0), .wdata0(wdata0),
    .w_ena1(w_ena1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_byp),
    .init_busy(busy_byp), .wr_err(err_byp), .collide(col_byp)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .w_ena0(w_ena0), .waddr0(waddr0), .wdata0(wdata0),
    .w_ena1(w_ena1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_nb),
    .init_busy(busy_nb), .wr_err(err_nb), .collide(col_nb)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // expected read value from the current model contents and the current inputs
  function automatic logic [31:0] model_read(input logic [4:0] ra, input bit fwd);
    if (model_clearing || ra == 5'd0) return 32'd0;
    if (fwd && w_ena1 && waddr1 == ra) return wdata1;
    if (fwd && w_ena0 && waddr0 == ra) return wdata0;
    return model_mem[ra];
  endfunction

  task automatic check_outputs();
    logic [4:0] ra;
    if (!armed) return;
    for (int k = 0; k < 2; k++) begin
      ra = raddr[k*5 +: 5];
      check_eq($sformatf("rdata_byp[%0d] addr %0d", k, ra), rdata_byp[k*32 +: 32], model_read(ra, 1'b1));
      check_eq($sformatf("rdata_nb[%0d] addr %0d", k, ra), rdata_nb[k*32 +: 32], model_read(ra, 1'b0));
    end
    check_eq("init_busy", {31'd0, busy_byp}, {31'd0, model_clearing});
    check_eq("init_busy_nb", {31'd0, busy_nb}, {31'd0, model_clearing});
    check_eq("wr_err", {31'd0, err_byp}, {31'd0, model_err});
    check_eq("wr_err_nb", {31'd0, err_nb}, {31'd0, model_err});
    check_eq("collide", {31'd0, col_byp}, {31'd0, model_col});
    check_eq("collide_nb", {31'd0, col_nb}, {31'd0, model_col});
  endtask

  // advance the model by one clock edge using the inputs applied this cycle
  task automatic update_model();
    if (rst) begin
      model_clearing = 1'b1;
      model_pos      = 0;
      model_err      = 1'b0;
      model_col      = 1'b0;
    end else if (model_clearing) begin
      model_mem[model_pos] = 32'd0;
      model_pos++;
      if (model_pos == 32) model_clearing = 1'b0;
      model_err = (w_ena0 && waddr0 != 5'd0) || (w_ena1 && waddr1 != 5'd0);
      model_col = 1'b0;
    end else begin
      if (w_ena0 && waddr0 != 5'd0) model_mem[waddr0] = wdata0;
      if (w_ena1 && waddr1 != 5'd0) model_mem[waddr1] = wdata1;
      model_col = w_ena0 && w_ena1 && waddr0 == waddr1 && waddr1 != 5'd0;
      model_err = 1'b0;
      if (clr_req) begin
        model_clearing = 1'b1;
        model_pos      = 0;
      end
    end
  endtask

  // one clock: check at the falling edge, step the model at the rising edge
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0;
    w_ena0  = 1'b0; waddr0 = 5'd0; wdata0 = 32'd0;
    w_ena1  = 1'b0; waddr1 = 5'd0; wdata1 = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
    model_clearing = 1'b0;
    model_pos      = 0;
    model_err      = 1'b0;
    model_col      = 1'b0;
    rst   = 1'b1;
    raddr = 10'd0;
    idle_inputs();

    // reset for one cycle, then walk every address through both read ports
    cycle();
    armed = 1'b1;
    rst   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      cycle();
    end
    check_eq("busy_after_32", {31'd0, busy_byp}, 32'd0);

    // single write with same-cycle forwarding on port 0
    w_ena0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    raddr  = {5'd5, 5'd5};
    cycle();
    idle_inputs();
    check_eq("nb_next_cycle", rdata_nb[31:0], 32'hDEADBEEF);
    cycle();

    // both ports hit address 7: port 1 wins and collide pulses
    w_ena0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    w_ena1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    raddr  = {5'd7, 5'd7};
    cycle();
    idle_inputs();
    check_eq("collide_pulse", {31'd0, col_byp}, 32'd1);
    check_eq("entry7", rdata_nb[31:0], 32'h22222222);
    cycle();
    check_eq("collide_gone", {31'd0, col_byp}, 32'd0);

    // writes to the zero entry are dropped silently
    w_ena0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    w_ena1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    raddr  = {5'd0, 5'd0};
    cycle();
    idle_inputs();
    cycle();

    // fill address 3, request a clear, attempt a write mid-clear
    w_ena0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    raddr  = {5'd4, 5'd3};
    cycle();
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_ena0 = (i == 10); waddr0 = 5'd4; wdata0 = 32'h12345678;
      cycle();
    end
    idle_inputs();
    check_eq("clear_done", {31'd0, busy_byp}, 32'd0);
    cycle();

    // reset in the middle of a clear restarts the sequence
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) cycle();
    check_eq("restart_done", {31'd0, busy_byp}, 32'd0);

    // randomized traffic with occasional clear requests and resets
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      w_ena0  = $urandom_range(0, 1);
      w_ena1  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        waddr0 = 5'($urandom_range(0, 3));
        waddr1 = 5'($urandom_range(0, 3));
        raddr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      end else begin
        waddr0 = 5'($urandom);
        waddr1 = 5'($urandom);
        raddr  = 10'($urandom);
      end
      wdata0 = $urandom;
      wdata1 = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
